// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issue stage feeding the 4-bit bit-serial ALU.
// Queues requests, holds each at the ALU for OP_CYCLES edges, returns C/flags.
// Optional expected-result model enabled by defining OPSEQ_SELFCHECK_EN.
// Revision: 1.0
`default_nettype none

module alu_op_sequencer #(
  parameter int DATA_W     = 4,
  parameter int OP_W       = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int OP_CYCLES  = 5,
  parameter logic [OP_W-1:0] IDLE_OP = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [OP_W-1:0]   in_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_opcode,
  input  logic [DATA_W-1:0] alu_c,
  input  logic              alu_zf,
  input  logic              alu_sf,
  input  logic              alu_cf,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_c,
  output logic              res_zf,
  output logic              res_sf,
  output logic              res_cf,
  output logic [OP_W-1:0]   res_op,
  output logic              res_err,
  output logic              res_mismatch
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int ENT_W = OP_W + 2*DATA_W;
  localparam int CNT_W = (OP_CYCLES > 1) ? $clog2(OP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(OP_CYCLES-1);

  localparam logic [OP_W-1:0] c_OP_XOR  = OP_W'(1);
  localparam logic [OP_W-1:0] c_OP_ADD  = OP_W'(2);
  localparam logic [OP_W-1:0] c_OP_XNOR = OP_W'(3);
  localparam logic [OP_W-1:0] c_OP_SUB  = OP_W'(4);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_ERR  = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]        r_state, w_state_nxt;
  logic [ENT_W-1:0]  r_mem [FIFO_DEPTH];
  logic [AW:0]       r_wp, r_rp;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_alu_a, r_alu_b;
  logic [OP_W-1:0]   r_alu_op;
  logic [DATA_W-1:0] r_res_c;
  logic              r_res_zf, r_res_sf, r_res_cf, r_res_err;
  logic [OP_W-1:0]   r_res_op;

  logic              w_full, w_empty, w_push, w_pop, w_legal, w_last;
  logic [OP_W-1:0]   w_h_op;
  logic [DATA_W-1:0] w_h_a, w_h_b;

  assign w_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_empty = (r_wp == r_rp);
  assign w_push  = in_valid && !w_full;
  assign w_pop   = (r_state == S_IDLE) && !w_empty;
  assign {w_h_op, w_h_a, w_h_b} = r_mem[r_rp[AW-1:0]];
  assign w_legal = (w_h_op == c_OP_XOR) || (w_h_op == c_OP_ADD) ||
                   (w_h_op == c_OP_XNOR) || (w_h_op == c_OP_SUB);
  assign w_last  = (r_cnt == c_CNT_LAST);

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (!w_empty) w_state_nxt = w_legal ? S_EXEC : S_ERR;
      S_EXEC:  if (w_last) w_state_nxt = S_HOLD;
      S_ERR:   w_state_nxt = S_HOLD;
      S_HOLD:  if (res_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready   = !w_full;
    res_valid  = (r_state == S_HOLD);
    alu_opcode = (r_state == S_EXEC) ? r_alu_op : IDLE_OP;
    alu_a      = r_alu_a;
    alu_b      = r_alu_b;
    res_c      = r_res_c;
    res_zf     = r_res_zf;
    res_sf     = r_res_sf;
    res_cf     = r_res_cf;
    res_op     = r_res_op;
    res_err    = r_res_err;
  end

  // FIFO storage needs no reset; only the pointers define occupancy.
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wp[AW-1:0]] <= {in_op, in_a, in_b};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wp      <= '0;
      r_rp      <= '0;
      r_cnt     <= '0;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_op  <= IDLE_OP;
      r_res_c   <= '0;
      r_res_zf  <= 1'b0;
      r_res_sf  <= 1'b0;
      r_res_cf  <= 1'b0;
      r_res_op  <= '0;
      r_res_err <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) begin
        r_rp     <= r_rp + 1'b1;
        r_res_op <= w_h_op;
        if (w_legal) begin
          r_alu_a   <= w_h_a;
          r_alu_b   <= w_h_b;
          r_alu_op  <= w_h_op;
          r_cnt     <= '0;
          r_res_err <= 1'b0;
        end else begin
          r_res_err <= 1'b1;
          r_res_c   <= '0;
          r_res_zf  <= 1'b0;
          r_res_sf  <= 1'b0;
          r_res_cf  <= 1'b0;
        end
      end
      if (r_state == S_EXEC) begin
        r_cnt <= r_cnt + 1'b1;
        if (w_last) begin
          r_res_c  <= alu_c;
          r_res_zf <= alu_zf;
          r_res_sf <= alu_sf;
          r_res_cf <= alu_cf;
        end
      end
    end
  end

`ifdef OPSEQ_SELFCHECK_EN
  logic [DATA_W-1:0] r_exp_c, w_exp_c;
  logic              r_exp_cf, w_exp_cf, r_chk_flags, r_mm;

  always_comb begin
    w_exp_c  = '0;
    w_exp_cf = 1'b0;
    case (w_h_op)
      c_OP_XOR:  w_exp_c = w_h_a ^ w_h_b;
      c_OP_XNOR: w_exp_c = ~(w_h_a ^ w_h_b);
      c_OP_ADD:  {w_exp_cf, w_exp_c} = {1'b0, w_h_a} + {1'b0, w_h_b};
      c_OP_SUB:  w_exp_c = w_h_a - w_h_b;
      default:   w_exp_c = '0;
    endcase
  end

  // SUB flag conventions are ALU-specific, so only C is compared for SUB.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_exp_c     <= '0;
      r_exp_cf    <= 1'b0;
      r_chk_flags <= 1'b0;
      r_mm        <= 1'b0;
    end else begin
      if (w_pop) begin
        r_exp_c     <= w_exp_c;
        r_exp_cf    <= w_exp_cf;
        r_chk_flags <= (w_h_op != c_OP_SUB);
        if (!w_legal) r_mm <= 1'b0;
      end
      if ((r_state == S_EXEC) && w_last) begin
        r_mm <= (alu_c != r_exp_c) ||
                (r_chk_flags && ((alu_zf != (r_exp_c == '0)) ||
                                 (alu_sf != r_exp_c[DATA_W-1]) ||
                                 (alu_cf != r_exp_cf)));
      end
    end
  end

  assign res_mismatch = r_mm;
`else
  assign res_mismatch = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed scoreboard bench with a timed behavioural ALU.
`default_nettype none

module tb_alu_op_sequencer;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       in_valid = 1'b0, in_ready;
  logic [3:0] in_a = '0, in_b = '0;
  logic [2:0] in_op = '0;
  logic [3:0] alu_a, alu_b, alu_c;
  logic [2:0] alu_opcode;
  logic       alu_zf, alu_sf, alu_cf;
  logic       res_valid, res_ready = 1'b0;
  logic [3:0] res_c;
  logic       res_zf, res_sf, res_cf, res_err, res_mismatch;
  logic [2:0] res_op;

  int n_checks = 0;
  int n_errors = 0;
  logic [11:0] q[$];

  always #5 CLK = ~CLK;

  alu_op_sequencer dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_c(alu_c), .alu_zf(alu_zf), .alu_sf(alu_sf), .alu_cf(alu_cf),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_c(res_c), .res_zf(res_zf), .res_sf(res_sf), .res_cf(res_cf),
    .res_op(res_op), .res_err(res_err), .res_mismatch(res_mismatch)
  );

  // ALU stand-in: result is only correct in its last state, so early capture shows.
  logic [2:0] r_alu_st;
  logic [4:0] w_sum;
  logic [3:0] w_c;
  logic       w_cf;
  always @(posedge CLK) r_alu_st <= (alu_opcode == 3'b000) ? 3'd0 : r_alu_st + 3'd1;
  always_comb begin
    w_sum = {1'b0, alu_a} + {1'b0, alu_b};
    w_c   = 4'h0;
    w_cf  = 1'b0;
    case (alu_opcode)
      3'b001: w_c = alu_a ^ alu_b;
      3'b010: {w_cf, w_c} = w_sum;
      3'b011: w_c = ~(alu_a ^ alu_b);
      3'b100: begin w_c = alu_a - alu_b; w_cf = (alu_a < alu_b); end
      default: w_c = 4'h0;
    endcase
    if (r_alu_st == 3'd4) begin
      alu_c = w_c; alu_zf = (w_c == 4'h0); alu_sf = w_c[3]; alu_cf = w_cf;
    end else begin
      alu_c = 4'hA; alu_zf = 1'b0; alu_sf = 1'b0; alu_cf = 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected response packing: {op, err, mismatch, zf, sf, cf, c}
  function automatic logic [11:0] E(input logic [2:0] op, input logic err,
                                    input logic [3:0] c, input logic zf,
                                    input logic sf, input logic cf);
    return {op, err, 1'b0, zf, sf, cf, c};
  endfunction

  always @(negedge CLK) begin
    if (!RST && res_valid && res_ready) begin
      if (q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_result: got %0h expected none",
                 {res_op, res_err, res_mismatch, res_zf, res_sf, res_cf, res_c});
      end else begin
        check("result", {20'd0, res_op, res_err, res_mismatch, res_zf, res_sf, res_cf, res_c},
              {20'd0, q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                      input logic [11:0] exp, input bit push);
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
    for (int k = 0; k < 100 && !in_ready; k++) tick();
    if (!in_ready) begin
      n_checks++; n_errors++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1");
    end
    tick();
    if (push) q.push_back(exp);
    in_valid = 1'b0;
  endtask

  task automatic timed(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                       input logic [11:0] exp, output int lat, output int opcnt);
    send(a, b, op, exp, 1'b1);
    lat = 0; opcnt = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (alu_opcode != 3'b000) opcnt++;
      if (res_valid && lat == 0) lat = k;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && q.size() != 0; k++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [3:0]  oa [7];
  logic [3:0]  ob [7];
  logic [2:0]  oo [7];
  logic [11:0] oe [7];

  initial begin
    int lat, opcnt, nacc;
    logic acc;

    tick(); tick();
    check("reset_res_valid", {31'd0, res_valid}, 32'd0);
    check("reset_alu_opcode", {29'd0, alu_opcode}, 32'd0);
    check("reset_alu_ab", {24'd0, alu_a, alu_b}, 32'd0);
    check("reset_res", {21'd0, res_c, res_op, res_err, res_zf, res_sf, res_cf}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    RST = 1'b0;
    res_ready = 1'b1;
    tick();

    timed(4'h5, 4'h3, 3'b001, E(3'b001, 1'b0, 4'h6, 1'b0, 1'b0, 1'b0), lat, opcnt);
    check("xor_latency", lat, 6);

    timed(4'h9, 4'h8, 3'b010, E(3'b010, 1'b0, 4'h1, 1'b0, 1'b0, 1'b1), lat, opcnt);
    check("add_latency", lat, 6);
    check("add_opcode_edges", opcnt, 5);

    send(4'h5, 4'h5, 3'b011, E(3'b011, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0), 1'b1);
    send(4'h7, 4'h7, 3'b001, E(3'b001, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0), 1'b1);
    drain();
    tick(); tick();

    timed(4'h3, 4'h1, 3'b110, E(3'b110, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0), lat, opcnt);
    check("illegal_latency", lat, 2);
    check("illegal_opcode_edges", opcnt, 0);

    // Back-pressure: one held result plus a full FIFO.
    res_ready = 1'b0;
    oa = '{4'h3, 4'h2, 4'hA, 4'h3, 4'hF, 4'h1, 4'h2};
    ob = '{4'h4, 4'h5, 4'h5, 4'hC, 4'h1, 4'h1, 4'h2};
    oo = '{3'b010, 3'b100, 3'b001, 3'b011, 3'b010, 3'b001, 3'b010};
    oe = '{E(3'b010, 1'b0, 4'h7, 1'b0, 1'b0, 1'b0),
           E(3'b100, 1'b0, 4'hD, 1'b0, 1'b1, 1'b1),
           E(3'b001, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0),
           E(3'b011, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0),
           E(3'b010, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1),
           E(3'b001, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0),
           E(3'b010, 1'b0, 4'h4, 1'b0, 1'b0, 1'b0)};
    nacc = 0;
    for (int i = 0; i < 7; i++) begin
      in_a = oa[i]; in_b = ob[i]; in_op = oo[i]; in_valid = 1'b1;
      acc = in_ready;
      tick();
      if (acc) begin
        nacc++;
        q.push_back(oe[i]);
      end
    end
    in_valid = 1'b0;
    check("capacity_accepted", nacc, 5);
    for (int k = 0; k < 10; k++) tick();
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    check("full_res_valid", {31'd0, res_valid}, 32'd1);
    check("held_res_c", {28'd0, res_c}, 32'h7);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    tick();
    check("pulse_in_ready", {31'd0, in_ready}, 32'd1);
    send(4'h9, 4'h4, 3'b100, E(3'b100, 1'b0, 4'h5, 1'b0, 1'b0, 1'b0), 1'b1);
    check("refull_in_ready", {31'd0, in_ready}, 32'd0);
    res_ready = 1'b1;
    drain();
    tick(); tick();

    // Reset while the ALU is mid-operation.
    send(4'h5, 4'h5, 3'b010, 12'h000, 1'b0);
    tick(); tick(); tick();
    RST = 1'b1;
    tick();
    check("rst_exec_opcode", {29'd0, alu_opcode}, 32'd0);
    check("rst_exec_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_exec_in_ready", {31'd0, in_ready}, 32'd1);
    RST = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    timed(4'h1, 4'h1, 3'b010, E(3'b010, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0), lat, opcnt);
    check("post_rst_latency", lat, 6);

    drain();
    check("scoreboard_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
